// File: rtl/cpu_mem_pkg.sv
// ----------------------------------------------------------------------------
// cpu_mem_pkg
// Shared encodings for the RV32I core's data-memory port and its responder.
//   - request-bit positions inside DATA_MEM_READ / DATA_MEM_WRITE
//   - load funct3 codes (LB, LH, LW, LBU, LHU)
//   - store size codes (SB, SH, SW); code 2'b11 is reserved
//   - responder FSM state type
// ----------------------------------------------------------------------------
package cpu_mem_pkg;

  // Bit that flags a live request in each request bus
  localparam int READ_EN  = 3;
  localparam int WRITE_EN = 2;

  // Load funct3 codes carried in DATA_MEM_READ[2:0]
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // Store size codes carried in DATA_MEM_WRITE[1:0]
  localparam logic [1:0] SB = 2'b00;
  localparam logic [1:0] SH = 2'b01;
  localparam logic [1:0] SW = 2'b10;

  // Responder FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// ----------------------------------------------------------------------------
// mem_lane_align
// Purely combinational byte-lane steering for the data-memory responder.
//   Store side: turns a store code and byte offset into a 4-bit byte enable
//   and replicates the store byte/half onto every lane it could land in.
//   Load side : picks the addressed byte/half out of the stored word and
//   sign- or zero-extends it according to funct3.
//   Both sides flag misaligned halfword/word accesses; the access itself is
//   done at the forced-aligned address (low offset bits dropped).
// Ports:
//   is_store   in   1  selects which direction drives 'misaligned'
//   addr_lo    in   2  byte offset within the word
//   ld_funct3  in   3  load type
//   st_code    in   2  store size
//   store_data in  32  raw store data from the core
//   mem_word   in  32  word read from the array
//   byte_en    out  4  lanes to write
//   write_word out 32  store data replicated onto lanes
//   load_data  out 32  extended load result
//   misaligned out  1  halfword at odd offset / word at non-zero offset
// ----------------------------------------------------------------------------
module mem_lane_align
  import cpu_mem_pkg::*;
(
  input  logic        is_store,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  st_code,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_word,
  output logic [3:0]  byte_en,
  output logic [31:0] write_word,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic        st_misaligned;
  logic        ld_misaligned;

  // Halfword lane uses only addr[1], which is exactly the forced alignment
  always_comb begin
    case (addr_lo)
      2'd0:    lane_byte = mem_word[7:0];
      2'd1:    lane_byte = mem_word[15:8];
      2'd2:    lane_byte = mem_word[23:16];
      default: lane_byte = mem_word[31:24];
    endcase
    lane_half = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];
  end

  // Store steering; the reserved code leaves every lane disabled
  always_comb begin
    byte_en       = 4'b0000;
    write_word    = store_data;
    st_misaligned = 1'b0;
    case (st_code)
      SB: begin
        byte_en    = 4'b0001 << addr_lo;
        write_word = {4{store_data[7:0]}};
      end
      SH: begin
        byte_en       = addr_lo[1] ? 4'b1100 : 4'b0011;
        write_word    = {2{store_data[15:0]}};
        st_misaligned = addr_lo[0];
      end
      SW: begin
        byte_en       = 4'b1111;
        write_word    = store_data;
        st_misaligned = |addr_lo;
      end
      default: begin
        byte_en       = 4'b0000;
        write_word    = store_data;
        st_misaligned = 1'b0;
      end
    endcase
  end

  // Load extension; undefined funct3 values return zero
  always_comb begin
    load_data     = 32'h0;
    ld_misaligned = 1'b0;
    case (ld_funct3)
      LB:  load_data = {{24{lane_byte[7]}}, lane_byte};
      LBU: load_data = {24'h0, lane_byte};
      LH: begin
        load_data     = {{16{lane_half[15]}}, lane_half};
        ld_misaligned = addr_lo[0];
      end
      LHU: begin
        load_data     = {16'h0, lane_half};
        ld_misaligned = addr_lo[0];
      end
      LW: begin
        load_data     = mem_word;
        ld_misaligned = |addr_lo;
      end
      default: begin
        load_data     = 32'h0;
        ld_misaligned = 1'b0;
      end
    endcase
  end

  assign misaligned = is_store ? st_misaligned : ld_misaligned;

endmodule

// File: rtl/data_mem_responder.sv
// ----------------------------------------------------------------------------
// data_mem_responder
// Slave end of the RV32I core's data-memory port. A request seen in IDLE is
// latched and the core is stalled for LATENCY ACCESS cycles plus the request
// cycle itself; the array operation happens on the last ACCESS cycle and the
// core is released in a one-cycle DONE state.
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (power of two); upper address bits wrap
//   LATENCY      ACCESS cycles per transaction (>= 1)
// Ports:
//   CLK                  in   1  clock, rising edge
//   RESET_N              in   1  asynchronous active-low reset
//   DATA_MEM_READ        in   4  [3] read request, [2:0] funct3
//   DATA_MEM_WRITE       in   3  [2] write request, [1:0] store size
//   DATA_MEM_ADDR        in  32  byte address
//   DATA_MEM_WRITE_DATA  in  32  store data
//   DATA_MEM_READ_DATA   out 32  extended load result, held between loads
//   DATA_MEM_BUSYWAIT    out  1  stall to the core
//   DATA_MEM_MISALIGNED  out  1  pulses in DONE of a misaligned access
// ----------------------------------------------------------------------------
module data_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 3
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [3:0]  DATA_MEM_READ,
  input  logic [2:0]  DATA_MEM_WRITE,
  input  logic [31:0] DATA_MEM_ADDR,
  input  logic [31:0] DATA_MEM_WRITE_DATA,
  output logic [31:0] DATA_MEM_READ_DATA,
  output logic        DATA_MEM_BUSYWAIT,
  output logic        DATA_MEM_MISALIGNED
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LATENCY - 1);

  logic              req_read;
  logic              req_write;
  logic              perform;
  logic              unused_addr_bits;

  mem_state_e        state_q,      state_d;
  logic [CNT_W-1:0]  cnt_q,        cnt_d;
  logic [IDX_W-1:0]  idx_q,        idx_d;
  logic [1:0]        lane_q,       lane_d;
  logic [31:0]       wdata_q,      wdata_d;
  logic              is_write_q,   is_write_d;
  logic              is_read_q,    is_read_d;
  logic [2:0]        ld_funct3_q,  ld_funct3_d;
  logic [1:0]        st_code_q,    st_code_d;
  logic [31:0]       read_data_q,  read_data_d;
  logic              misaligned_q, misaligned_d;

  logic [31:0]       mem_array [DEPTH_WORDS];
  logic [31:0]       mem_word;
  logic [3:0]        byte_en;
  logic [31:0]       write_word;
  logic [31:0]       load_data;
  logic              access_misaligned;

  assign req_read  = DATA_MEM_READ[READ_EN];
  assign req_write = DATA_MEM_WRITE[WRITE_EN];

  // Address bits above the array index are deliberately ignored (wrap)
  assign unused_addr_bits = ^DATA_MEM_ADDR[31:IDX_W+2];

  assign mem_word = mem_array[idx_q];

  mem_lane_align u_lane_align (
    .is_store   (is_write_q),
    .addr_lo    (lane_q),
    .ld_funct3  (ld_funct3_q),
    .st_code    (st_code_q),
    .store_data (wdata_q),
    .mem_word   (mem_word),
    .byte_en    (byte_en),
    .write_word (write_word),
    .load_data  (load_data),
    .misaligned (access_misaligned)
  );

  // Last ACCESS cycle: the array is touched and the result captured here
  assign perform = (state_q == ACCESS) && (cnt_q == LAST_CNT);

  // Next-state logic. When read and write arrive together the write wins and
  // the read is dropped, so READ_DATA keeps its previous value.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    lane_d       = lane_q;
    wdata_d      = wdata_q;
    is_write_d   = is_write_q;
    is_read_d    = is_read_q;
    ld_funct3_d  = ld_funct3_q;
    st_code_d    = st_code_q;
    read_data_d  = read_data_q;
    misaligned_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_read || req_write) begin
          state_d     = ACCESS;
          cnt_d       = '0;
          idx_d       = DATA_MEM_ADDR[IDX_W+1:2];
          lane_d      = DATA_MEM_ADDR[1:0];
          wdata_d     = DATA_MEM_WRITE_DATA;
          is_write_d  = req_write;
          is_read_d   = req_read && !req_write;
          ld_funct3_d = DATA_MEM_READ[2:0];
          st_code_d   = DATA_MEM_WRITE[1:0];
        end
      end
      ACCESS: begin
        if (perform) begin
          state_d      = DONE;
          cnt_d        = '0;
          misaligned_d = access_misaligned;
          if (is_read_q) begin
            read_data_d = load_data;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        // A request still asserted here is picked up only from IDLE
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and result registers; reset abandons any transaction in flight
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      lane_q       <= '0;
      wdata_q      <= '0;
      is_write_q   <= 1'b0;
      is_read_q    <= 1'b0;
      ld_funct3_q  <= '0;
      st_code_q    <= '0;
      read_data_q  <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      lane_q       <= lane_d;
      wdata_q      <= wdata_d;
      is_write_q   <= is_write_d;
      is_read_q    <= is_read_d;
      ld_funct3_q  <= ld_funct3_d;
      st_code_q    <= st_code_d;
      read_data_q  <= read_data_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Word array, byte-write capable. Not reset: contents survive RESET_N, and
  // since reset forces IDLE a write that was still in ACCESS never lands.
  always_ff @(posedge CLK) begin
    if (perform && is_write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem_array[idx_q][8*b +: 8] <= write_word[8*b +: 8];
        end
      end
    end
  end

  // Busywait is combinational in IDLE so the core stalls in its request cycle
  assign DATA_MEM_BUSYWAIT   = ((state_q == IDLE) && (req_read || req_write)) ||
                               (state_q == ACCESS);
  assign DATA_MEM_READ_DATA  = read_data_q;
  assign DATA_MEM_MISALIGNED = misaligned_q;

endmodule
